// File: rtl/register_file.sv
// register_file: 2**A x N register file, two combinational read ports, optional write bypass and hardwired zero register
module register_file #(
  parameter int N        = 32,
  parameter int A        = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         wr_en_in,
  input  logic [A-1:0] wr_addr_in,
  input  logic [N-1:0] wr_data_in,
  input  logic [A-1:0] rd_addr_a_in,
  output logic [N-1:0] rd_data_a_out,
  input  logic [A-1:0] rd_addr_b_in,
  output logic [N-1:0] rd_data_b_out
);
  logic [N-1:0] regs_q [2**A];
  logic         wr_ok_d;
  logic         fwd_a_d;
  logic         fwd_b_d;
  always_comb begin
    wr_ok_d = wr_en_in && !(ZERO_REG != 0 && wr_addr_in == '0);
    fwd_a_d = BYPASS != 0 && rst && wr_ok_d && rd_addr_a_in == wr_addr_in;
    fwd_b_d = BYPASS != 0 && rst && wr_ok_d && rd_addr_b_in == wr_addr_in;
    rd_data_a_out = (ZERO_REG != 0 && rd_addr_a_in == '0) ? '0 : fwd_a_d ? wr_data_in : regs_q[rd_addr_a_in];
    rd_data_b_out = (ZERO_REG != 0 && rd_addr_b_in == '0) ? '0 : fwd_b_d ? wr_data_in : regs_q[rd_addr_b_in];
  end
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      for (int i = 0; i < 2**A; i++) regs_q[i] <= '0;
    end else if (wr_ok_d) begin
      regs_q[wr_addr_in] <= wr_data_in;
    end
  end
endmodule
